// File: rtl/rtc_time_counter.sv
// Time-of-day counter fed by rtc_timer base ticks: seconds prescaler, hh:mm:ss in binary,
// validated set port, rollover strobes and a sticky alarm flag.
module rtc_time_counter #(
   parameter int unsigned TICKS_PER_SEC = 100,
   parameter int unsigned PRESC_W       = 7
) (
   input  logic       i_sclk,
   input  logic       i_reset,
   input  logic       i_basetick,
   input  logic       i_run,
   input  logic       i_set,
   input  logic [4:0] i_set_hh,
   input  logic [5:0] i_set_mm,
   input  logic [5:0] i_set_ss,
   input  logic       i_alarm_en,
   input  logic [4:0] i_alarm_hh,
   input  logic [5:0] i_alarm_mm,
   input  logic       i_alarm_clr,
   output logic [4:0] o_hh,
   output logic [5:0] o_mm,
   output logic [5:0] o_ss,
   output logic       o_sec_pulse,
   output logic       o_min_pulse,
   output logic       o_day_pulse,
   output logic       o_set_err,
   output logic       o_alarm
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic               set_ok;
   logic               sec_adv;
   logic               ss_wrap;
   logic               mm_wrap;
   logic               hh_wrap;
   logic               alarm_hit;
   logic [4:0]         hh_nxt;
   logic [5:0]         mm_nxt;
   logic [5:0]         ss_nxt;

   // A set request in the same cycle always swallows the tick.
   always_comb begin
      tick    = i_basetick & i_run & ~i_set;
      set_ok  = (i_set_hh <= 5'd23) && (i_set_mm <= 6'd59) && (i_set_ss <= 6'd59);
      sec_adv = tick && (presc == PRESC_MAX);
      ss_wrap = (o_ss == 6'd59);
      mm_wrap = (o_mm == 6'd59);
      hh_wrap = (o_hh == 5'd23);
      ss_nxt  = ss_wrap ? '0 : o_ss + 6'd1;
      mm_nxt  = o_mm;
      hh_nxt  = o_hh;
      if (ss_wrap) begin
         mm_nxt = mm_wrap ? '0 : o_mm + 6'd1;
         if (mm_wrap) begin
            hh_nxt = hh_wrap ? '0 : o_hh + 5'd1;
         end
      end
      // New seconds value is zero exactly when the seconds field wraps.
      alarm_hit = sec_adv && i_alarm_en && ss_wrap &&
                  (mm_nxt == i_alarm_mm) && (hh_nxt == i_alarm_hh);
   end

   always_ff @(posedge i_sclk or posedge i_reset) begin
      if (i_reset) begin
         presc       <= '0;
         o_hh        <= '0;
         o_mm        <= '0;
         o_ss        <= '0;
         o_sec_pulse <= 1'b0;
         o_min_pulse <= 1'b0;
         o_day_pulse <= 1'b0;
         o_set_err   <= 1'b0;
         o_alarm     <= 1'b0;
      end else begin
         o_sec_pulse <= sec_adv;
         o_min_pulse <= sec_adv && ss_wrap;
         o_day_pulse <= sec_adv && ss_wrap && mm_wrap && hh_wrap;
         o_set_err   <= i_set && !set_ok;

         if (i_set) begin
            if (set_ok) begin
               o_hh  <= i_set_hh;
               o_mm  <= i_set_mm;
               o_ss  <= i_set_ss;
               presc <= '0;
            end
         end else if (tick) begin
            if (sec_adv) begin
               presc <= '0;
               o_hh  <= hh_nxt;
               o_mm  <= mm_nxt;
               o_ss  <= ss_nxt;
            end else begin
               presc <= presc + 1'b1;
            end
         end

         if (alarm_hit) begin
            o_alarm <= 1'b1;
         end else if (i_alarm_clr) begin
            o_alarm <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter (4 ticks per second) with a seconds-of-day
// reference model feeding an expectation queue checked one edge later.
module tb_rtc_time_counter;

   logic       i_sclk = 1'b0;
   logic       i_reset;
   logic       i_basetick;
   logic       i_run;
   logic       i_set;
   logic [4:0] i_set_hh;
   logic [5:0] i_set_mm;
   logic [5:0] i_set_ss;
   logic       i_alarm_en;
   logic [4:0] i_alarm_hh;
   logic [5:0] i_alarm_mm;
   logic       i_alarm_clr;
   logic [4:0] o_hh;
   logic [5:0] o_mm;
   logic [5:0] o_ss;
   logic       o_sec_pulse;
   logic       o_min_pulse;
   logic       o_day_pulse;
   logic       o_set_err;
   logic       o_alarm;

   rtc_time_counter #(.TICKS_PER_SEC(4), .PRESC_W(2)) dut (
      .i_sclk(i_sclk), .i_reset(i_reset), .i_basetick(i_basetick), .i_run(i_run),
      .i_set(i_set), .i_set_hh(i_set_hh), .i_set_mm(i_set_mm), .i_set_ss(i_set_ss),
      .i_alarm_en(i_alarm_en), .i_alarm_hh(i_alarm_hh), .i_alarm_mm(i_alarm_mm),
      .i_alarm_clr(i_alarm_clr), .o_hh(o_hh), .o_mm(o_mm), .o_ss(o_ss),
      .o_sec_pulse(o_sec_pulse), .o_min_pulse(o_min_pulse), .o_day_pulse(o_day_pulse),
      .o_set_err(o_set_err), .o_alarm(o_alarm)
   );

   always #5 i_sclk = ~i_sclk;

   typedef struct {
      int hh, mm, ss, sec, min, day, err, alarm;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_day    = 0;
   int   m_tod    = 0;
   int   m_presc  = 0;
   int   m_alarm  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $display("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
         $error("%s check did not hold", tag);
      end
   endtask

   task automatic model_reset();
      m_tod   = 0;
      m_presc = 0;
      m_alarm = 0;
   endtask

   // Reference model steps on the current inputs, then the DUT edge is compared.
   task automatic cycle();
      exp_t e;
      exp_t got;
      bit   adv;
      adv = 0;
      e   = '{default: 0};
      if (i_set) begin
         if (i_set_hh <= 23 && i_set_mm <= 59 && i_set_ss <= 59) begin
            m_tod   = int'(i_set_hh) * 3600 + int'(i_set_mm) * 60 + int'(i_set_ss);
            m_presc = 0;
         end else begin
            e.err = 1;
         end
      end else if (i_basetick && i_run) begin
         if (m_presc < 3) m_presc++;
         else begin
            m_presc = 0;
            adv     = 1;
         end
      end
      if (adv) begin
         e.sec = 1;
         if (m_tod == 86399) begin
            m_tod = 0;
            e.day = 1;
         end else begin
            m_tod++;
         end
         if (m_tod % 60 == 0) e.min = 1;
      end
      if (adv && i_alarm_en && m_tod == int'(i_alarm_hh) * 3600 + int'(i_alarm_mm) * 60)
         m_alarm = 1;
      else if (i_alarm_clr)
         m_alarm = 0;
      e.hh    = m_tod / 3600;
      e.mm    = (m_tod / 60) % 60;
      e.ss    = m_tod % 60;
      e.alarm = m_alarm;
      q.push_back(e);

      @(posedge i_sclk);
      #1;
      if (o_day_pulse === 1'b1) n_day++;
      if (q.size() == 0) begin
         check("queue_underflow", 32'd1, 32'd0);
      end else begin
         got = q.pop_front();
         check("hh",    32'(o_hh),        32'(got.hh));
         check("mm",    32'(o_mm),        32'(got.mm));
         check("ss",    32'(o_ss),        32'(got.ss));
         check("sec",   32'(o_sec_pulse), 32'(got.sec));
         check("min",   32'(o_min_pulse), 32'(got.min));
         check("day",   32'(o_day_pulse), 32'(got.day));
         check("err",   32'(o_set_err),   32'(got.err));
         check("alarm", 32'(o_alarm),     32'(got.alarm));
      end
   endtask

   task automatic tick_gap(input int n);
      repeat (n) begin
         i_basetick = 1'b1;
         cycle();
         i_basetick = 1'b0;
         cycle();
      end
   endtask

   task automatic tick_b2b(input int n);
      i_basetick = 1'b1;
      repeat (n) cycle();
      i_basetick = 1'b0;
   endtask

   task automatic do_set(input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
      i_set    = 1'b1;
      i_set_hh = hh;
      i_set_mm = mm;
      i_set_ss = ss;
      cycle();
      i_set = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_hh"},    32'(o_hh),        32'd0);
      check({tag, "_mm"},    32'(o_mm),        32'd0);
      check({tag, "_ss"},    32'(o_ss),        32'd0);
      check({tag, "_sec"},   32'(o_sec_pulse), 32'd0);
      check({tag, "_min"},   32'(o_min_pulse), 32'd0);
      check({tag, "_day"},   32'(o_day_pulse), 32'd0);
      check({tag, "_err"},   32'(o_set_err),   32'd0);
      check({tag, "_alarm"}, 32'(o_alarm),     32'd0);
   endtask

   initial begin
      i_reset     = 1'b1;
      i_basetick  = 1'b0;
      i_run       = 1'b0;
      i_set       = 1'b0;
      i_set_hh    = '0;
      i_set_mm    = '0;
      i_set_ss    = '0;
      i_alarm_en  = 1'b0;
      i_alarm_hh  = '0;
      i_alarm_mm  = '0;
      i_alarm_clr = 1'b0;
      #2;
      check_all_zero("reset");
      @(posedge i_sclk);
      #1;
      i_reset = 1'b0;
      model_reset();

      // 1: prescaler divides by four
      i_run = 1'b1;
      tick_gap(3);
      check("t1_ss_after3", 32'(o_ss), 32'd0);
      i_basetick = 1'b1;
      cycle();
      check("t1_ss_after4", 32'(o_ss), 32'd1);
      check("t1_sec_pulse", 32'(o_sec_pulse), 32'd1);
      i_basetick = 1'b0;
      cycle();
      check("t1_sec_pulse_drop", 32'(o_sec_pulse), 32'd0);

      // 2: day rollover
      do_set(5'd23, 6'd59, 6'd58);
      n_day = 0;
      tick_gap(4);
      check("t2_ss59", 32'(o_ss), 32'd59);
      tick_gap(3);
      i_basetick = 1'b1;
      cycle();
      check("t2_hms_zero", {o_hh, o_mm, o_ss}, 32'd0);
      check("t2_min_day", {o_min_pulse, o_day_pulse}, 32'd3);
      i_basetick = 1'b0;
      cycle();
      check("t2_day_once", 32'(n_day), 32'd1);

      // 3: rejected set, set wins over a concurrent tick
      do_set(5'd5, 6'd60, 6'd0);
      check("t3_set_err", 32'(o_set_err), 32'd1);
      check("t3_hh_kept", 32'(o_hh), 32'd0);
      cycle();
      check("t3_err_drop", 32'(o_set_err), 32'd0);
      tick_gap(3);
      i_basetick = 1'b1;
      do_set(5'd10, 6'd20, 6'd30);
      i_basetick = 1'b0;
      check("t3_loaded_ss", 32'(o_ss), 32'd30);
      check("t3_no_sec", 32'(o_sec_pulse), 32'd0);
      tick_gap(3);
      check("t3_presc_cleared", 32'(o_ss), 32'd30);
      tick_gap(1);
      check("t3_ss31", 32'(o_ss), 32'd31);

      // 4: alarm set, clear, match beats clear, enable gating
      i_alarm_en = 1'b1;
      i_alarm_hh = 5'd0;
      i_alarm_mm = 6'd1;
      do_set(5'd0, 6'd0, 6'd59);
      tick_gap(4);
      check("t4_alarm_set", 32'(o_alarm), 32'd1);
      i_alarm_clr = 1'b1;
      cycle();
      i_alarm_clr = 1'b0;
      check("t4_alarm_clr", 32'(o_alarm), 32'd0);
      do_set(5'd0, 6'd0, 6'd59);
      tick_gap(3);
      i_basetick  = 1'b1;
      i_alarm_clr = 1'b1;
      cycle();
      i_basetick  = 1'b0;
      i_alarm_clr = 1'b0;
      check("t4_match_wins", 32'(o_alarm), 32'd1);
      i_alarm_en = 1'b0;
      cycle();
      check("t4_en_off_holds", 32'(o_alarm), 32'd1);
      i_alarm_clr = 1'b1;
      cycle();
      i_alarm_clr = 1'b0;
      i_alarm_en  = 1'b1;
      do_set(5'd0, 6'd1, 6'd0);
      check("t4_set_no_alarm", 32'(o_alarm), 32'd0);

      // 5: run gating and back-to-back ticks
      do_set(5'd1, 6'd2, 6'd3);
      tick_gap(2);
      i_run = 1'b0;
      tick_gap(10);
      check("t5_held", 32'(o_ss), 32'd3);
      i_run = 1'b1;
      tick_gap(1);
      check("t5_presc_held", 32'(o_ss), 32'd3);
      tick_gap(1);
      check("t5_ss4", 32'(o_ss), 32'd4);
      tick_b2b(4);
      check("t5_b2b", 32'(o_ss), 32'd5);

      // 6: asynchronous reset mid-second
      do_set(5'd12, 6'd34, 6'd56);
      tick_gap(2);
      #2;
      i_reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      model_reset();
      @(posedge i_sclk);
      #1;
      i_reset = 1'b0;
      tick_gap(3);
      check("t6_partial_discarded", 32'(o_ss), 32'd0);
      tick_gap(1);
      check("t6_resume", {o_hh, o_mm, o_ss}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
